// File: rtl/zpu_stack_fetch.sv
// ZPU register-fetch stage: tracks the stack pointer, forms port-A read addresses and
// expands multi-beat opcodes. Define ZPU_SP_BOUNDS_EN to enable sticky stack-bounds fault detection.
module zpu_stack_fetch #(
    parameter int          SP_W        = 30,
    parameter int          PC_W        = 32,
    parameter int          INST_W      = 5,
    parameter int          OFS_W       = 5,
    parameter logic [31:0] STACK_TOP   = 32'h1fff,
    parameter logic [31:0] STACK_LIMIT = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              stall,
    input  logic              stallexe,
    input  logic              flush,
    input  logic [INST_W-1:0] decodedinst,
    input  logic [1:0]        spstateadr,
    input  logic [1:0]        spstate,
    input  logic [SP_W-1:0]   tos,
    input  logic [OFS_W-1:0]  instofset,
    input  logic [6:0]        instvalue,
    input  logic [PC_W-1:0]   pcin,
    input  logic [PC_W-1:0]   nextpcin,
    input  logic [7:0]        instructiondbgin,
    output logic [SP_W-1:0]   mem_adr_a,
    output logic              mem_enable_a,
    output logic [INST_W-1:0] instout,
    output logic [6:0]        instoutvalue,
    output logic [SP_W-1:0]   offset,
    output logic [SP_W-1:0]   destiny,
    output logic [SP_W-1:0]   spout,
    output logic [PC_W-1:0]   pcout,
    output logic [PC_W-1:0]   nextpcout,
    output logic [7:0]        instructiondbgout,
    output logic              sp_fault
);

    // Execute-stage opcode codes this stage recognises or emits.
    localparam logic [INST_W-1:0] EXE_NOP       = INST_W'(0);
    localparam logic [INST_W-1:0] EXE_STORE     = INST_W'(3);
    localparam logic [INST_W-1:0] EXE_POPSP     = INST_W'(5);
    localparam logic [INST_W-1:0] EXE_STORESP   = INST_W'(13);
    localparam logic [INST_W-1:0] EXE_STORESP1  = INST_W'(14);
    localparam logic [INST_W-1:0] EXE_STORESP2  = INST_W'(15);
    localparam logic [INST_W-1:0] EXE_NEQBRANCH = INST_W'(19);
    localparam logic [INST_W-1:0] EXE_STOREB    = INST_W'(20);
    localparam logic [INST_W-1:0] EXE_STORE2    = INST_W'(21);
    localparam logic [INST_W-1:0] EXE_MOV       = INST_W'(22);

    localparam logic [1:0] ADR_STAY = 2'd0;
    localparam logic [1:0] ADR_INC  = 2'd1;
    localparam logic [1:0] ADR_OFS  = 2'd2;
    localparam logic [1:0] SP_INC   = 2'd0;
    localparam logic [1:0] SP_DEC   = 2'd1;
    localparam logic [1:0] SP_TOS   = 2'd2;

    localparam logic [31:0]     TOP_ALIGNED = (STACK_TOP - 32'd4) & ~32'd3;
    localparam logic [SP_W-1:0] SP_INIT     = SP_W'(TOP_ALIGNED);

    typedef enum logic {RUN, SEQ} state_t;
    typedef enum logic [1:0] {KIND_STORE, KIND_BR, KIND_POPSP} kind_t;

    state_t          state;
    kind_t           kind;
    logic [1:0]      beats;
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_plus4;
    logic [SP_W-1:0] read_addr;
    logic [SP_W-1:0] next_sp;
    logic            popsp_last;
    logic            is_multi;

    assign sp_plus4 = sp + SP_W'(4);

    always_comb begin
        read_addr = tos;
        case (spstateadr)
            ADR_STAY: read_addr = sp_plus4;
            ADR_INC:  read_addr = sp + SP_W'(8);
            ADR_OFS:  read_addr = sp + (SP_W'(instofset) << 2);
            default:  read_addr = tos;
        endcase
    end

    always_comb begin
        next_sp = sp;
        case (spstate)
            SP_INC:  next_sp = sp_plus4;
            SP_DEC:  next_sp = sp - SP_W'(4);
            SP_TOS:  next_sp = tos;
            default: next_sp = sp;
        endcase
    end

    // Last popsp beat re-reads the word just above the freshly loaded SP.
    assign popsp_last   = (state == SEQ) && (kind == KIND_POPSP) && (beats == 2'd1);
    assign mem_adr_a    = popsp_last ? sp_plus4 : read_addr;
    assign mem_enable_a = popsp_last || (spstateadr != ADR_STAY);

    assign is_multi = (decodedinst == EXE_STORE) || (decodedinst == EXE_STOREB) ||
                      (decodedinst == EXE_POPSP) || (decodedinst == EXE_NEQBRANCH);
    assign stall    = stallexe || ((state == RUN) && is_multi) || ((state == SEQ) && (beats > 2'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= RUN;
            kind              <= KIND_STORE;
            beats             <= 2'd0;
            sp                <= SP_INIT;
            spout             <= SP_INIT;
            instout           <= EXE_NOP;
            instoutvalue      <= '0;
            offset            <= '0;
            destiny           <= '0;
            pcout             <= '0;
            nextpcout         <= '0;
            instructiondbgout <= 8'h01;
        end else if (flush) begin
            state             <= RUN;
            beats             <= 2'd0;
            instout           <= EXE_NOP;
            offset            <= sp_plus4;
            instructiondbgout <= 8'h01;
        end else if (!stallexe) begin
            spout             <= sp;
            pcout             <= pcin;
            nextpcout         <= nextpcin;
            instoutvalue      <= instvalue;
            instructiondbgout <= instructiondbgin;
            if (state == RUN) begin
                offset  <= read_addr;
                sp      <= next_sp;
                destiny <= next_sp;
                instout <= decodedinst;
                case (decodedinst)
                    EXE_STORE, EXE_STOREB: begin
                        state <= SEQ;
                        beats <= 2'd1;
                        kind  <= KIND_STORE;
                    end
                    EXE_NEQBRANCH: begin
                        state <= SEQ;
                        beats <= 2'd1;
                        kind  <= KIND_BR;
                    end
                    EXE_POPSP: begin
                        instout <= EXE_NOP;
                        state   <= SEQ;
                        beats   <= 2'd2;
                        kind    <= KIND_POPSP;
                    end
                    EXE_STORESP, EXE_STORESP1, EXE_STORESP2: begin
                        destiny <= SP_W'(instofset) << 2;
                    end
                    default: begin
                    end
                endcase
            end else begin
                beats   <= beats - 2'd1;
                instout <= (kind == KIND_STORE) ? EXE_STORE2 : EXE_MOV;
                if (beats == 2'd1) begin
                    state <= RUN;
                end
                if (popsp_last) begin
                    offset  <= sp_plus4;
                    destiny <= sp_plus4;
                end else begin
                    offset  <= read_addr;
                    sp      <= next_sp;
                    destiny <= next_sp;
                end
            end
        end
    end

`ifdef ZPU_SP_BOUNDS_EN
    localparam logic [SP_W-1:0] SP_LIMIT = SP_W'(STACK_LIMIT);

    logic sp_write;
    assign sp_write = !flush && !stallexe && !popsp_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_fault <= 1'b0;
        end else if (sp_write && ((next_sp < SP_LIMIT) || (next_sp > SP_INIT))) begin
            sp_fault <= 1'b1;
        end
    end
`else
    assign sp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_zpu_stack_fetch.sv
// Self-checking bench for zpu_stack_fetch: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_zpu_stack_fetch;

    localparam int SP_W   = 30;
    localparam int PC_W   = 32;
    localparam int INST_W = 5;
    localparam int OFS_W  = 5;

`ifdef ZPU_SP_BOUNDS_EN
    localparam bit          BOUNDS = 1'b1;
    localparam logic [31:0] LIMIT  = 32'h1ff0;
`else
    localparam bit          BOUNDS = 1'b0;
    localparam logic [31:0] LIMIT  = 32'h0;
`endif

    localparam logic [SP_W-1:0] SP_INIT  = 30'h1ff8;
    localparam logic [SP_W-1:0] LIMIT_SP = SP_W'(LIMIT);
    localparam logic [SP_W-1:0] FOUR     = 30'd4;
    localparam logic [SP_W-1:0] EIGHT    = 30'd8;

    localparam logic [4:0] NOP = 5'd0, STORE = 5'd3, POPSP = 5'd5, ADD = 5'd6;
    localparam logic [4:0] STORESP = 5'd13, STORESP1 = 5'd14, STORESP2 = 5'd15;
    localparam logic [4:0] NEQB = 5'd19, STOREB = 5'd20, STORE2 = 5'd21, MOV = 5'd22;

    localparam logic [1:0] A_STAY = 2'd0, A_INC = 2'd1, A_OFS = 2'd2, A_TOS = 2'd3;
    localparam logic [1:0] S_INC = 2'd0, S_DEC = 2'd1, S_TOS = 2'd2, S_STAY = 2'd3;

    localparam int BEAT_STORE = 1, BEAT_BR = 2, BEAT_POP_UPD = 3, BEAT_POP_HOLD = 4;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              stallexe;
    logic              flush;
    logic [INST_W-1:0] decodedinst;
    logic [1:0]        spstateadr;
    logic [1:0]        spstate;
    logic [SP_W-1:0]   tos;
    logic [OFS_W-1:0]  instofset;
    logic [6:0]        instvalue;
    logic [PC_W-1:0]   pcin;
    logic [PC_W-1:0]   nextpcin;
    logic [7:0]        instructiondbgin;
    logic [SP_W-1:0]   mem_adr_a;
    logic              mem_enable_a;
    logic [INST_W-1:0] instout;
    logic [6:0]        instoutvalue;
    logic [SP_W-1:0]   offset;
    logic [SP_W-1:0]   destiny;
    logic [SP_W-1:0]   spout;
    logic [PC_W-1:0]   pcout;
    logic [PC_W-1:0]   nextpcout;
    logic [7:0]        instructiondbgout;
    logic              sp_fault;

    zpu_stack_fetch #(
        .SP_W(SP_W), .PC_W(PC_W), .INST_W(INST_W), .OFS_W(OFS_W),
        .STACK_TOP(32'h1fff), .STACK_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .stallexe(stallexe), .flush(flush),
        .decodedinst(decodedinst), .spstateadr(spstateadr), .spstate(spstate),
        .tos(tos), .instofset(instofset), .instvalue(instvalue), .pcin(pcin),
        .nextpcin(nextpcin), .instructiondbgin(instructiondbgin),
        .mem_adr_a(mem_adr_a), .mem_enable_a(mem_enable_a), .instout(instout),
        .instoutvalue(instoutvalue), .offset(offset), .destiny(destiny),
        .spout(spout), .pcout(pcout), .nextpcout(nextpcout),
        .instructiondbgout(instructiondbgout), .sp_fault(sp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic sx, input logic [4:0] op,
                                 input logic [1:0] asel, input logic [1:0] ssel,
                                 input logic [SP_W-1:0] t, input logic [4:0] o);
        @(negedge clk);
        rst              = r;
        flush            = f;
        stallexe         = sx;
        decodedinst      = op;
        spstateadr       = asel;
        spstate          = ssel;
        tos              = t;
        instofset        = o;
        instvalue        = 7'($urandom);
        pcin             = $urandom;
        nextpcin         = $urandom;
        instructiondbgin = 8'($urandom);
    endtask

    // Reference model: SP and registered outputs plus a queue of pending sequencer beats.
    logic [SP_W-1:0] m_sp, m_spout, m_off, m_dest;
    logic [4:0]      m_inst;
    logic [6:0]      m_ival;
    logic [PC_W-1:0] m_pc, m_npc;
    logic [7:0]      m_dbg;
    logic            m_fault;
    int              beat_q[$];

    function automatic logic [SP_W-1:0] modelRead();
        case (spstateadr)
            A_STAY:  return m_sp + FOUR;
            A_INC:   return m_sp + EIGHT;
            A_OFS:   return m_sp + SP_W'(instofset) * FOUR;
            default: return tos;
        endcase
    endfunction

    function automatic logic [SP_W-1:0] modelNext();
        case (spstate)
            S_INC:   return m_sp + FOUR;
            S_DEC:   return m_sp - FOUR;
            S_TOS:   return tos;
            default: return m_sp;
        endcase
    endfunction

    function automatic bit holdBeat();
        return (beat_q.size() > 0) && (beat_q[0] == BEAT_POP_HOLD);
    endfunction

    function automatic logic modelStall();
        bit multi;
        multi = (decodedinst == STORE) || (decodedinst == STOREB) ||
                (decodedinst == POPSP) || (decodedinst == NEQB);
        return stallexe || ((beat_q.size() == 0) && multi) || (beat_q.size() > 1);
    endfunction

    task automatic modelReset();
        m_sp = SP_INIT; m_spout = SP_INIT; m_inst = NOP; m_ival = '0;
        m_off = '0; m_dest = '0; m_pc = '0; m_npc = '0; m_dbg = 8'h01; m_fault = 1'b0;
        beat_q.delete();
    endtask

    task automatic modelStep();
        logic [SP_W-1:0] rd, nd;
        bit wr;
        int b;
        rd = modelRead();
        nd = modelNext();
        wr = 1'b0;
        if (rst) begin
            modelReset();
        end else if (flush) begin
            m_inst = NOP; m_off = m_sp + FOUR; m_dbg = 8'h01;
            beat_q.delete();
        end else if (!stallexe) begin
            m_spout = m_sp; m_pc = pcin; m_npc = nextpcin;
            m_ival = instvalue; m_dbg = instructiondbgin;
            if (beat_q.size() == 0) begin
                m_off = rd; m_dest = nd; m_inst = decodedinst; wr = 1'b1;
                if (decodedinst == STORE || decodedinst == STOREB) beat_q.push_back(BEAT_STORE);
                else if (decodedinst == NEQB) beat_q.push_back(BEAT_BR);
                else if (decodedinst == POPSP) begin
                    m_inst = NOP;
                    beat_q.push_back(BEAT_POP_UPD);
                    beat_q.push_back(BEAT_POP_HOLD);
                end else if (decodedinst == STORESP || decodedinst == STORESP1 || decodedinst == STORESP2)
                    m_dest = SP_W'(instofset) * FOUR;
            end else begin
                b = beat_q.pop_front();
                if (b == BEAT_POP_HOLD) begin
                    m_inst = MOV; m_off = m_sp + FOUR; m_dest = m_sp + FOUR;
                end else begin
                    m_inst = (b == BEAT_STORE) ? STORE2 : MOV;
                    m_off = rd; m_dest = nd; wr = 1'b1;
                end
            end
            if (wr) begin
                m_sp = nd;
                if (BOUNDS && ((nd < LIMIT_SP) || (nd > SP_INIT))) m_fault = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic            r, f, sx;
        logic [4:0]      op;
        logic [1:0]      asel, ssel;
        logic [SP_W-1:0] t;
        logic [4:0]      o;
        logic            e_stall;
        logic [SP_W-1:0] e_adr;
        logic            e_en;
        logic [4:0]      e_inst;
        logic [SP_W-1:0] e_off, e_dest, e_spout;
    } vec_t;

    vec_t vecs[22];

    initial begin
        // r f sx op asel ssel tos ofs | stall adr en | inst offset destiny spout
        vecs[0]  = '{0,0,0,ADD,   A_INC, S_DEC, 0,0,         0,30'h2000,1,     ADD,   30'h2000,30'h1ff4,30'h1ff8};
        vecs[1]  = '{0,0,0,NOP,   A_STAY,S_STAY,0,0,         0,30'h1ff8,0,     NOP,   30'h1ff8,30'h1ff4,30'h1ff4};
        vecs[2]  = '{0,0,0,STORE, A_STAY,S_INC, 0,0,         1,30'h1ff8,0,     STORE, 30'h1ff8,30'h1ff8,30'h1ff4};
        vecs[3]  = '{0,0,0,NOP,   A_INC, S_INC, 0,0,         0,30'h2000,1,     STORE2,30'h2000,30'h1ffc,30'h1ff8};
        vecs[4]  = '{0,0,0,NOP,   A_STAY,S_STAY,0,0,         0,30'h2000,0,     NOP,   30'h2000,30'h1ffc,30'h1ffc};
        vecs[5]  = '{0,0,0,STORESP,A_OFS,S_INC, 0,3,         0,30'h2008,1,     STORESP,30'h2008,30'h000c,30'h1ffc};
        vecs[6]  = '{0,0,0,POPSP, A_TOS, S_TOS, 30'h1000,0,  1,30'h1000,1,     NOP,   30'h1000,30'h1000,30'h2000};
        vecs[7]  = '{0,0,0,NOP,   A_STAY,S_STAY,0,0,         1,30'h1004,0,     MOV,   30'h1004,30'h1000,30'h1000};
        vecs[8]  = '{0,0,0,NOP,   A_STAY,S_DEC, 0,0,         0,30'h1004,1,     MOV,   30'h1004,30'h1004,30'h1000};
        vecs[9]  = '{0,0,0,NOP,   A_STAY,S_STAY,0,0,         0,30'h1004,0,     NOP,   30'h1004,30'h1000,30'h1000};
        vecs[10] = '{0,0,0,POPSP, A_STAY,S_DEC, 0,0,         1,30'h1004,0,     NOP,   30'h1004,30'h0ffc,30'h1000};
        vecs[11] = '{0,1,1,NOP,   A_INC, S_STAY,0,0,         1,30'h1004,1,     NOP,   30'h1000,30'h0ffc,30'h1000};
        vecs[12] = '{0,0,0,NOP,   A_STAY,S_STAY,0,0,         0,30'h1000,0,     NOP,   30'h1000,30'h0ffc,30'h0ffc};
        vecs[13] = '{0,0,1,ADD,   A_INC, S_DEC, 0,0,         1,30'h1004,1,     NOP,   30'h1000,30'h0ffc,30'h0ffc};
        vecs[14] = '{0,0,0,NEQB,  A_INC, S_INC, 0,0,         1,30'h1004,1,     NEQB,  30'h1004,30'h1000,30'h0ffc};
        vecs[15] = '{0,0,0,STOREB,A_STAY,S_INC, 0,0,         0,30'h1004,0,     MOV,   30'h1004,30'h1004,30'h1000};
        vecs[16] = '{0,0,0,STOREB,A_STAY,S_DEC, 0,0,         1,30'h1008,0,     STOREB,30'h1008,30'h1000,30'h1004};
        vecs[17] = '{1,0,0,NOP,   A_STAY,S_STAY,0,0,         0,30'h1004,0,     NOP,   30'h0000,30'h0000,30'h1ff8};
        vecs[18] = '{0,0,0,NOP,   A_STAY,S_STAY,0,0,         0,30'h1ffc,0,     NOP,   30'h1ffc,30'h1ff8,30'h1ff8};
        vecs[19] = '{0,0,0,NOP,   A_OFS, S_TOS, 30'h3ffffffc,31, 0,30'h2074,1, NOP,   30'h2074,30'h3ffffffc,30'h1ff8};
        vecs[20] = '{0,0,0,NOP,   A_INC, S_INC, 0,0,         0,30'h0004,1,     NOP,   30'h0004,30'h0000,30'h3ffffffc};
        vecs[21] = '{0,0,0,NOP,   A_STAY,S_DEC, 0,0,         0,30'h0004,0,     NOP,   30'h0004,30'h3ffffffc,30'h0000};

        // Reset state
        applyStimulus(1, 0, 0, NOP, A_STAY, S_STAY, 0, 0);
        applyStimulus(1, 0, 0, NOP, A_STAY, S_STAY, 0, 0);
        @(posedge clk); #1;
        checkOutput("reset.spout", spout, SP_INIT);
        checkOutput("reset.instout", instout, NOP);
        checkOutput("reset.dbg", instructiondbgout, 8'h01);
        checkOutput("reset.offset", offset, 0);
        checkOutput("reset.destiny", destiny, 0);
        checkOutput("reset.pcout", pcout, 0);
        checkOutput("reset.fault", sp_fault, 0);

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].r, vecs[i].f, vecs[i].sx, vecs[i].op,
                          vecs[i].asel, vecs[i].ssel, vecs[i].t, vecs[i].o);
            #1;
            checkOutput($sformatf("row%0d.stall", i), stall, vecs[i].e_stall);
            checkOutput($sformatf("row%0d.mem_adr_a", i), mem_adr_a, vecs[i].e_adr);
            checkOutput($sformatf("row%0d.mem_enable_a", i), mem_enable_a, vecs[i].e_en);
            @(posedge clk); #1;
            checkOutput($sformatf("row%0d.instout", i), instout, vecs[i].e_inst);
            checkOutput($sformatf("row%0d.offset", i), offset, vecs[i].e_off);
            checkOutput($sformatf("row%0d.destiny", i), destiny, vecs[i].e_dest);
            checkOutput($sformatf("row%0d.spout", i), spout, vecs[i].e_spout);
        end
        checkOutput("flush.dbg_after_row", instructiondbgout, instructiondbgin);

        // Stack-bounds sequence: three pushes from reset, then pop, then reset
        applyStimulus(1, 0, 0, NOP, A_STAY, S_STAY, 0, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, ADD, A_STAY, S_DEC, 0, 0);
            @(posedge clk); #1;
            checkOutput($sformatf("bounds.push%0d", k), sp_fault, (BOUNDS && k == 2) ? 1'b1 : 1'b0);
        end
        applyStimulus(0, 0, 0, ADD, A_STAY, S_INC, 0, 0);
        @(posedge clk); #1;
        checkOutput("bounds.sticky", sp_fault, BOUNDS);
        applyStimulus(1, 0, 0, NOP, A_STAY, S_STAY, 0, 0);
        @(posedge clk); #1;
        checkOutput("bounds.cleared", sp_fault, 0);

        // Randomized run against the reference model
        modelReset();
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 4) == 0, 5'($urandom_range(0, 23)),
                          2'($urandom), 2'($urandom), SP_W'($urandom), 5'($urandom));
            #1;
            checkOutput("rand.stall", stall, modelStall());
            checkOutput("rand.mem_adr_a", mem_adr_a, holdBeat() ? m_sp + FOUR : modelRead());
            checkOutput("rand.mem_enable_a", mem_enable_a, holdBeat() || (spstateadr != A_STAY));
            modelStep();
            @(posedge clk); #1;
            checkOutput("rand.instout", instout, m_inst);
            checkOutput("rand.offset", offset, m_off);
            checkOutput("rand.destiny", destiny, m_dest);
            checkOutput("rand.spout", spout, m_spout);
            checkOutput("rand.pcout", pcout, m_pc);
            checkOutput("rand.nextpcout", nextpcout, m_npc);
            checkOutput("rand.instoutvalue", instoutvalue, m_ival);
            checkOutput("rand.dbg", instructiondbgout, m_dbg);
            checkOutput("rand.sp_fault", sp_fault, m_fault);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
